// File: rtl/spart_receiver.sv
// SPART receive path: 16x-oversampled 8N1 receiver with a single-entry buffer.
// Optional macro SPART_RX_MAJORITY_EN selects 2-of-3 majority bit sampling.
module spart_receiver (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxenable,
    input  logic       rxd,
    input  logic       rd_ack,
    output logic [7:0] rx_data,
    output logic       rda,
    output logic       framing_err,
    output logic       overrun,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

`ifdef SPART_RX_MAJORITY_EN
    localparam logic [3:0] START_DEC = 4'd8;
`else
    localparam logic [3:0] START_DEC = 4'd7;
`endif
    localparam logic [3:0] BIT_DEC = 4'd15;

    state_t     state_q, state_d;
    logic       rxd_meta_q, rxd_s_q, rxd_q, rxd_d;
    logic [3:0] tcnt_q, tcnt_d;
    logic [2:0] bidx_q, bidx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rda_q, rda_d;
    logic       fe_q, fe_d;
    logic       ov_q, ov_d;
    logic [3:0] dec_pt;
    logic       at_dec;
    logic       bit_val;
`ifdef SPART_RX_MAJORITY_EN
    logic [1:0] samp_q, samp_d;
`endif

    // Buffer handshake: rda is "valid", rd_ack is the one-cycle consume strobe.
    // A completing frame always wins over rd_ack in the same cycle.
    always_comb begin
        state_d   = state_q;
        rxd_d     = rxd_s_q;
        tcnt_d    = tcnt_q;
        bidx_d    = bidx_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        rda_d     = rda_q;
        fe_d      = fe_q;
        ov_d      = ov_q;
        dec_pt    = (state_q == START) ? START_DEC : BIT_DEC;
        at_dec    = rxenable && (tcnt_q == dec_pt);
`ifdef SPART_RX_MAJORITY_EN
        samp_d    = samp_q;
        if (rxenable && state_q != IDLE) begin
            if (tcnt_q == dec_pt - 4'd2) samp_d[0] = rxd_s_q;
            if (tcnt_q == dec_pt - 4'd1) samp_d[1] = rxd_s_q;
        end
        bit_val   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_s_q) | (samp_q[1] & rxd_s_q);
`else
        bit_val   = rxd_s_q;
`endif
        if (rxenable && state_q != IDLE) tcnt_d = tcnt_q + 4'd1;
        if (rd_ack) begin
            rda_d = 1'b0;
            fe_d  = 1'b0;
            ov_d  = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (rxd_q && !rxd_s_q) begin
                    tcnt_d  = 4'd0;
                    state_d = START;
                end
            end
            START: begin
                if (at_dec) begin
                    if (!bit_val) begin
                        tcnt_d  = 4'd0;
                        bidx_d  = 3'd0;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (at_dec) begin
                    shift_d = {bit_val, shift_q[7:1]};
                    bidx_d  = bidx_q + 3'd1;
                    if (bidx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                // Returning to IDLE here lets a start edge late in the stop bit be caught.
                if (at_dec) begin
                    rx_data_d = shift_q;
                    rda_d     = 1'b1;
                    fe_d      = (fe_q & ~rd_ack) | ~bit_val;
                    ov_d      = ~rd_ack & (ov_q | rda_q);
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
            rxd_q      <= 1'b1;
            state_q    <= IDLE;
            tcnt_q     <= 4'd0;
            bidx_q     <= 3'd0;
            shift_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            rda_q      <= 1'b0;
            fe_q       <= 1'b0;
            ov_q       <= 1'b0;
`ifdef SPART_RX_MAJORITY_EN
            samp_q     <= 2'b11;
`endif
        end else begin
            rxd_meta_q <= rxd;
            rxd_s_q    <= rxd_meta_q;
            rxd_q      <= rxd_d;
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            bidx_q     <= bidx_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rda_q      <= rda_d;
            fe_q       <= fe_d;
            ov_q       <= ov_d;
`ifdef SPART_RX_MAJORITY_EN
            samp_q     <= samp_d;
`endif
        end
    end

    assign rx_data     = rx_data_q;
    assign rda         = rda_q;
    assign framing_err = fe_q;
    assign overrun     = ov_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_spart_receiver.sv
// Bench for spart_receiver: directed and random 8N1 frames, 4 clk per tick, 64 clk per bit.
module tb_spart_receiver;

    logic       clk = 1'b0;
    logic       rst, rxenable, rxd, rd_ack;
    logic [7:0] rx_data;
    logic       rda, framing_err, overrun;
    logic [1:0] dbg_state;

`ifdef SPART_RX_MAJORITY_EN
    localparam int STOP_TICK = 153;
`else
    localparam int STOP_TICK = 152;
`endif
    localparam int BIT_CLK = 64;

    int tests_run = 0;
    int tests_failed = 0;
    int div_cnt = 0;

    logic       obs_rda;
    logic [7:0] obs_data;

    // Reference state of the buffer, updated from frame-level events only.
    logic [7:0] exp_data;
    logic       exp_rda, exp_fe, exp_ov;
    logic [7:0] exp_q[$];

    spart_receiver dut (
        .clk(clk), .rst(rst), .rxenable(rxenable), .rxd(rxd), .rd_ack(rd_ack),
        .rx_data(rx_data), .rda(rda), .framing_err(framing_err), .overrun(overrun),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required finish");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic d, input logic ack);
        @(negedge clk);
        obs_rda  = rda;
        obs_data = rx_data;
        rxd      = d;
        rd_ack   = ack;
        rxenable = (div_cnt == 3);
        div_cnt  = (div_cnt + 1) % 4;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0);
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop_v, input logic ack);
        if (ack) begin
            exp_ov = 1'b0;
            exp_fe = ~stop_v;
        end else begin
            exp_ov = exp_ov | exp_rda;
            exp_fe = exp_fe | ~stop_v;
        end
        exp_data = b;
        exp_rda  = 1'b1;
    endtask

    task automatic ack_pulse();
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        exp_rda = 1'b0;
        exp_fe  = 1'b0;
        exp_ov  = 1'b0;
    endtask

    // Cycle j=0 is the first low cycle; the edge is seen in cycle 2, so ticks count from cycle 3.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic ack_at_stop,
                              input logic b2b, input int abort_at,
                              output logic rda_js, output logic rda_nx,
                              output logic [7:0] data_nx, output int js);
        logic [9:0] fr;
        int j, ticks;
        logic ack;
        fr = {stop_v, b, 1'b0};
        j = 0; ticks = 0; js = -1;
        rda_js = 1'bx; rda_nx = 1'bx; data_nx = 8'hxx;
        while (j < 10 * BIT_CLK && !(abort_at >= 0 && j >= abort_at) && !(b2b && js >= 0 && j >= js + 4)) begin
            ack = 1'b0;
            if (j >= 3 && div_cnt == 3) begin
                ticks++;
                if (ticks == STOP_TICK) begin
                    js  = j;
                    ack = ack_at_stop;
                end
            end
            drive(fr[j / BIT_CLK], ack);
            if (js >= 0 && j == js) rda_js = obs_rda;
            if (js >= 0 && j == js + 1) begin
                rda_nx  = obs_rda;
                data_nx = obs_data;
            end
            j++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; rxd = 1'b1; rd_ack = 1'b0; rxenable = 1'b0;
        exp_data = 8'h00; exp_rda = 1'b0; exp_fe = 1'b0; exp_ov = 1'b0;
        idle(5);
        tests_run++;
        if ({rx_data, rda, framing_err, overrun} !== 11'h000) begin
            tests_failed++;
            $display("FAIL reset_outputs: got data=%h rda=%b fe=%b ov=%b, required 00 0 0 0", rx_data, rda, framing_err, overrun);
        end
        tests_run++;
        if (dbg_state !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d, required idle (0)", dbg_state);
        end
        @(negedge clk); rst = 1'b1;
        idle(20);
    endtask

    task automatic test_basic();
        logic r0, r1; logic [7:0] d1; int js;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, -1, r0, r1, d1, js);
        model_frame(8'hA5, 1'b1, 1'b0);
        idle(4);
        tests_run++;
        if (js < 0 || r0 !== 1'b0 || r1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_latency: got js=%0d rda@stop=%b rda@stop+1=%b, required 0 then 1", js, r0, r1);
        end
        tests_run++;
        if ({rx_data, rda, framing_err, overrun} !== {exp_data, exp_rda, exp_fe, exp_ov}) begin
            tests_failed++;
            $display("FAIL basic_outputs: got %h %b%b%b, required %h %b%b%b", rx_data, rda, framing_err, overrun, exp_data, exp_rda, exp_fe, exp_ov);
        end
        ack_pulse();
        idle(2);
        tests_run++;
        if ({rx_data, rda, framing_err, overrun} !== {exp_data, exp_rda, exp_fe, exp_ov}) begin
            tests_failed++;
            $display("FAIL basic_ack: got %h %b%b%b, required %h %b%b%b", rx_data, rda, framing_err, overrun, exp_data, exp_rda, exp_fe, exp_ov);
        end
    endtask

    task automatic test_false_start();
        logic mid_state_ok;
        mid_state_ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0);
            if (i == 10) mid_state_ok = (dbg_state !== 2'd0);
        end
        idle(100);
        tests_run++;
        if (!mid_state_ok) begin
            tests_failed++;
            $display("FAIL false_start_detect: got idle during low pulse, required start detected");
        end
        tests_run++;
        if (dbg_state !== 2'd0 || rda !== exp_rda) begin
            tests_failed++;
            $display("FAIL false_start_return: got state=%0d rda=%b, required 0 and %b", dbg_state, rda, exp_rda);
        end
    endtask

    task automatic test_framing();
        logic r0, r1; logic [7:0] d1; int js;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1, r0, r1, d1, js);
        model_frame(8'h3C, 1'b0, 1'b0);
        idle(8);
        tests_run++;
        if ({rx_data, rda, framing_err, overrun} !== {exp_data, exp_rda, exp_fe, exp_ov}) begin
            tests_failed++;
            $display("FAIL framing_outputs: got %h %b%b%b, required %h %b%b%b", rx_data, rda, framing_err, overrun, exp_data, exp_rda, exp_fe, exp_ov);
        end
        ack_pulse();
        idle(2);
        tests_run++;
        if ({rx_data, rda, framing_err, overrun} !== {exp_data, exp_rda, exp_fe, exp_ov}) begin
            tests_failed++;
            $display("FAIL framing_ack: got %h %b%b%b, required %h %b%b%b", rx_data, rda, framing_err, overrun, exp_data, exp_rda, exp_fe, exp_ov);
        end
    endtask

    task automatic test_overrun();
        logic r0, r1; logic [7:0] d1; int js;
        for (int pass = 0; pass < 2; pass++) begin
            send_frame(8'h11, 1'b1, 1'b0, 1'b0, -1, r0, r1, d1, js);
            model_frame(8'h11, 1'b1, 1'b0);
            idle(20);
            send_frame(8'h22, 1'b1, pass == 1, 1'b0, -1, r0, r1, d1, js);
            model_frame(8'h22, 1'b1, pass == 1);
            idle(4);
            tests_run++;
            if ({rx_data, rda, framing_err, overrun} !== {exp_data, exp_rda, exp_fe, exp_ov}) begin
                tests_failed++;
                $display("FAIL overrun_pass%0d: got %h %b%b%b, required %h %b%b%b", pass, rx_data, rda, framing_err, overrun, exp_data, exp_rda, exp_fe, exp_ov);
            end
            if (pass == 0) ack_pulse();
        end
    endtask

    task automatic test_back_to_back();
        logic r0, r1; logic [7:0] d1, d2; int js;
        ack_pulse();
        idle(10);
        send_frame(8'h00, 1'b1, 1'b0, 1'b1, -1, r0, r1, d1, js);
        model_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0, -1, r0, r1, d2, js);
        model_frame(8'hFF, 1'b1, 1'b0);
        idle(4);
        tests_run++;
        if (d1 !== 8'h00 || d2 !== 8'hFF) begin
            tests_failed++;
            $display("FAIL b2b_bytes: got %h then %h, required 00 then ff", d1, d2);
        end
        tests_run++;
        if ({rx_data, rda, framing_err, overrun} !== {exp_data, exp_rda, exp_fe, exp_ov}) begin
            tests_failed++;
            $display("FAIL b2b_outputs: got %h %b%b%b, required %h %b%b%b", rx_data, rda, framing_err, overrun, exp_data, exp_rda, exp_fe, exp_ov);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic r0, r1; logic [7:0] d1; int js;
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 5 * BIT_CLK + 30, r0, r1, d1, js);
        @(negedge clk);
        rst = 1'b0; rxd = 1'b1; rxenable = 1'b0;
        #1;
        exp_data = 8'h00; exp_rda = 1'b0; exp_fe = 1'b0; exp_ov = 1'b0;
        tests_run++;
        if ({rx_data, rda, framing_err, overrun} !== 11'h000 || dbg_state !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_mid: got %h %b%b%b state=%0d, required 00 000 state=0", rx_data, rda, framing_err, overrun, dbg_state);
        end
        idle(3);
        @(negedge clk); rst = 1'b1;
        idle(50);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, -1, r0, r1, d1, js);
        model_frame(8'h5A, 1'b1, 1'b0);
        idle(4);
        tests_run++;
        if ({rx_data, rda, framing_err, overrun} !== {exp_data, exp_rda, exp_fe, exp_ov}) begin
            tests_failed++;
            $display("FAIL reset_recover: got %h %b%b%b, required %h %b%b%b", rx_data, rda, framing_err, overrun, exp_data, exp_rda, exp_fe, exp_ov);
        end
    endtask

    task automatic test_random();
        logic r0, r1; logic [7:0] d1, b, want; logic stop_v, ack; int js;
        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(0, 2) == 0) ack_pulse();
            idle($urandom_range(4, 40));
            b      = 8'($urandom_range(0, 255));
            stop_v = ($urandom_range(0, 3) != 0);
            ack    = ($urandom_range(0, 2) == 0);
            exp_q.push_back(b);
            send_frame(b, stop_v, ack, 1'b0, -1, r0, r1, d1, js);
            model_frame(b, stop_v, ack);
            idle(4);
            want = exp_q.pop_front();
            tests_run++;
            if (d1 !== want || r1 !== 1'b1) begin
                tests_failed++;
                $display("FAIL random_byte%0d: got %h rda=%b at stop+1, required %h rda=1", it, d1, r1, want);
            end
            tests_run++;
            if ({rx_data, rda, framing_err, overrun} !== {exp_data, exp_rda, exp_fe, exp_ov}) begin
                tests_failed++;
                $display("FAIL random_state%0d: got %h %b%b%b, required %h %b%b%b", it, rx_data, rda, framing_err, overrun, exp_data, exp_rda, exp_fe, exp_ov);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_framing();
        test_overrun();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
